// File: rtl/bitmask_skip_scheduler.sv
// bitmask_skip_scheduler
// Walks the set bits of a 16-bit weight mask MSB first, one beat per cycle,
// so the bit-serial shift-add lanes only spend cycles on nonzero weight bits.
// An all-zero mask produces a single empty beat flagged by out_zero.
// Beats per mask are capped at MAX_BEATS; lower set bits past the cap are dropped.
// Optional feature macro: SKIP_SCHED_PERF_CNT_EN adds saturating counters
// perf_masks (accepted masks) and perf_beats (completed output handshakes).
module bitmask_skip_scheduler #(
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_pos,
   output logic             out_last,
   output logic             out_zero
`ifdef SKIP_SCHED_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_masks,
   output logic [CNT_W-1:0] perf_beats
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ZERO = 2'd2
   } state_t;

   // Out-of-range parameters would silently mis-size the cap compare or counters.
   if (MAX_BEATS < 1 || MAX_BEATS > 16) begin : g_badMaxBeats
      $error("MAX_BEATS must be in 1..16");
   end
   if (CNT_W < 1) begin : g_badCntW
      $error("CNT_W must be at least 1");
   end

   localparam logic [3:0] LAST_CNT = 4'(MAX_BEATS - 1);

   state_t      r_state, w_stateNext;
   logic [15:0] r_mask, w_maskNext;
   logic [3:0]  r_cnt, w_cntNext;
   logic [3:0]  w_hiPos;
   logic        w_oneHot;
   logic        w_fire;
   logic        w_accept;

   // Leading-one encoder: later (higher) set bits override lower ones.
   always_comb begin
      w_hiPos = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (r_mask[i]) w_hiPos = 4'(i);
      end
   end

   assign w_oneHot = (r_mask != 16'd0) && ((r_mask & (r_mask - 16'd1)) == 16'd0);

   // Output beat decode; everything is held stable under backpressure because
   // it depends only on registered state.
   always_comb begin
      out_valid = 1'b0;
      out_pos   = 4'd0;
      out_last  = 1'b0;
      out_zero  = 1'b0;
      case (r_state)
         RUN: begin
            out_valid = 1'b1;
            out_pos   = w_hiPos;
            out_last  = w_oneHot || (r_cnt == LAST_CNT);
         end
         ZERO: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_zero  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_fire   = out_valid & out_ready;
   assign in_ready = (r_state == IDLE) | (w_fire & out_last);
   assign w_accept = in_valid & in_ready;

   // Next-state logic: retire the emitted bit, finish on the last beat, and
   // let a same-cycle accept start the next mask without a bubble.
   always_comb begin
      w_stateNext = r_state;
      w_maskNext  = r_mask;
      w_cntNext   = r_cnt;
      if (w_fire && !out_last) begin
         w_maskNext[w_hiPos] = 1'b0;
         w_cntNext           = r_cnt + 4'd1;
      end
      if (w_fire && out_last) begin
         w_stateNext = IDLE;
      end
      if (w_accept) begin
         w_maskNext  = in_mask;
         w_cntNext   = 4'd0;
         w_stateNext = (in_mask == 16'd0) ? ZERO : RUN;
      end
   end

   // State, mask and beat counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_mask  <= 16'd0;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_stateNext;
         r_mask  <= w_maskNext;
         r_cnt   <= w_cntNext;
      end
   end

`ifdef SKIP_SCHED_PERF_CNT_EN
   logic [CNT_W-1:0] r_perfMasks, r_perfBeats;

   // Saturating event counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_perfMasks <= '0;
         r_perfBeats <= '0;
      end else begin
         if (w_accept && (r_perfMasks != '1)) r_perfMasks <= r_perfMasks + 1'b1;
         if (w_fire && (r_perfBeats != '1))   r_perfBeats <= r_perfBeats + 1'b1;
      end
   end

   assign perf_masks = r_perfMasks;
   assign perf_beats = r_perfBeats;
`endif

endmodule

// File: tb/tb_bitmask_skip_scheduler.sv
// tb_bitmask_skip_scheduler
// Directed scenarios against a default build and a MAX_BEATS=2 build.
// Beat outputs are compared as the packed vector {valid, pos[3:0], last, zero}.
module tb_bitmask_skip_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid, inReady, outValid, outReady, outLast, outZero;
   logic [15:0] inMask;
   logic [3:0]  outPos;
   logic        inValidB, inReadyB, outValidB, outReadyB, outLastB, outZeroB;
   logic [15:0] inMaskB;
   logic [3:0]  outPosB;
`ifdef SKIP_SCHED_PERF_CNT_EN
   logic [15:0] perfMasks, perfBeats, perfMasksB, perfBeatsB;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   bitmask_skip_scheduler #(.MAX_BEATS(16), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(inValid), .in_ready(inReady), .in_mask(inMask),
      .out_valid(outValid), .out_ready(outReady), .out_pos(outPos),
      .out_last(outLast), .out_zero(outZero)
`ifdef SKIP_SCHED_PERF_CNT_EN
      , .perf_masks(perfMasks), .perf_beats(perfBeats)
`endif
   );

   bitmask_skip_scheduler #(.MAX_BEATS(2), .CNT_W(16)) dutCap (
      .clk(clk), .reset(reset),
      .in_valid(inValidB), .in_ready(inReadyB), .in_mask(inMaskB),
      .out_valid(outValidB), .out_ready(outReadyB), .out_pos(outPosB),
      .out_last(outLastB), .out_zero(outZeroB)
`ifdef SKIP_SCHED_PERF_CNT_EN
      , .perf_masks(perfMasksB), .perf_beats(perfBeatsB)
`endif
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; inValid = 1'b0; inMask = 16'h0; outReady = 1'b0;
      inValidB = 1'b0; inMaskB = 16'h0; outReadyB = 1'b0;
      nextCycle();
      nextCycle();
      reset = 1'b0;
      nextCycle();
      testsRun++;
      if ({outValid, outPos, outLast, outZero} !== 7'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got %b expected %b", {outValid, outPos, outLast, outZero}, 7'd0);
      end
      testsRun++;
      if (inReady !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady);
      end
      testsRun++;
      if ({outValidB, inReadyB} !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL reset_cap_dut: got %b expected 01", {outValidB, inReadyB});
      end
`ifdef SKIP_SCHED_PERF_CNT_EN
      testsRun++;
      if ({perfMasks, perfBeats} !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_perf: got %h expected 0", {perfMasks, perfBeats});
      end
`endif
   endtask

   task automatic test_sparse_mask();
      logic [6:0] expBeat [4];
      expBeat[0] = {1'b1, 4'd15, 1'b0, 1'b0};
      expBeat[1] = {1'b1, 4'd13, 1'b0, 1'b0};
      expBeat[2] = {1'b1, 4'd2,  1'b0, 1'b0};
      expBeat[3] = {1'b1, 4'd0,  1'b1, 1'b0};
      inValid = 1'b1; inMask = 16'hA005; outReady = 1'b1;
      nextCycle();
      inValid = 1'b0; inMask = 16'h0;
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if ({outValid, outPos, outLast, outZero} !== expBeat[i]) begin
            testsFailed++;
            $display("[TB] FAIL sparse_beat%0d: got %b expected %b", i, {outValid, outPos, outLast, outZero}, expBeat[i]);
         end
         testsRun++;
         if (inReady !== (i == 3)) begin
            testsFailed++;
            $display("[TB] FAIL sparse_in_ready%0d: got %b expected %b", i, inReady, (i == 3));
         end
         nextCycle();
      end
      testsRun++;
      if (outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL sparse_idle: got %b expected 0", outValid);
      end
`ifdef SKIP_SCHED_PERF_CNT_EN
      testsRun++;
      if ({perfMasks, perfBeats} !== {16'd1, 16'd4}) begin
         testsFailed++;
         $display("[TB] FAIL sparse_perf: got %h expected %h", {perfMasks, perfBeats}, {16'd1, 16'd4});
      end
`endif
   endtask

   task automatic test_zero_mask();
      inValid = 1'b1; inMask = 16'h0000; outReady = 1'b1;
      nextCycle();
      inValid = 1'b0;
      testsRun++;
      if ({outValid, outPos, outLast, outZero} !== {1'b1, 4'd0, 1'b1, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL zero_beat: got %b expected %b", {outValid, outPos, outLast, outZero}, {1'b1, 4'd0, 1'b1, 1'b1});
      end
      nextCycle();
      testsRun++;
      if ({outValid, inReady, outZero} !== 3'b010) begin
         testsFailed++;
         $display("[TB] FAIL zero_idle: got %b expected 010", {outValid, inReady, outZero});
      end
   endtask

   task automatic test_single_bits();
      logic [15:0] masks [2];
      logic [3:0]  poss [2];
      masks[0] = 16'h8000; poss[0] = 4'd15;
      masks[1] = 16'h0001; poss[1] = 4'd0;
      outReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         inValid = 1'b1; inMask = masks[i];
         nextCycle();
         inValid = 1'b0;
         testsRun++;
         if ({outValid, outPos, outLast, outZero} !== {1'b1, poss[i], 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL single_bit%0d: got %b expected %b", i, {outValid, outPos, outLast, outZero}, {1'b1, poss[i], 1'b1, 1'b0});
         end
         nextCycle();
         testsRun++;
         if (outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_idle%0d: got %b expected 0", i, outValid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] expBeat [3];
      expBeat[0] = {1'b1, 4'd1,  1'b0, 1'b0};
      expBeat[1] = {1'b1, 4'd0,  1'b1, 1'b0};
      expBeat[2] = {1'b1, 4'd15, 1'b1, 1'b0};
      inValid = 1'b1; inMask = 16'h0003; outReady = 1'b1;
      nextCycle();
      inMask = 16'h8000;
      for (int i = 0; i < 3; i++) begin
         testsRun++;
         if ({outValid, outPos, outLast, outZero} !== expBeat[i]) begin
            testsFailed++;
            $display("[TB] FAIL b2b_beat%0d: got %b expected %b", i, {outValid, outPos, outLast, outZero}, expBeat[i]);
         end
         if (i == 0) begin
            testsRun++;
            if (inReady !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL b2b_busy_ready: got %b expected 0", inReady);
            end
         end
         nextCycle();
         if (i == 1) inValid = 1'b0;
      end
      testsRun++;
      if (outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_idle: got %b expected 0", outValid);
      end
   endtask

   task automatic test_backpressure();
      inValid = 1'b1; inMask = 16'h0C00; outReady = 1'b1;
      nextCycle();
      inValid = 1'b0; outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         testsRun++;
         if ({outValid, outPos, outLast, outZero} !== {1'b1, 4'd11, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold%0d: got %b expected %b", i, {outValid, outPos, outLast, outZero}, {1'b1, 4'd11, 1'b0, 1'b0});
         end
         nextCycle();
      end
      outReady = 1'b1;
      testsRun++;
      if ({outValid, outPos, outLast} !== {1'b1, 4'd11, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL bp_beat0: got %b expected %b", {outValid, outPos, outLast}, {1'b1, 4'd11, 1'b0});
      end
      nextCycle();
      testsRun++;
      if ({outValid, outPos, outLast} !== {1'b1, 4'd10, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL bp_beat1: got %b expected %b", {outValid, outPos, outLast}, {1'b1, 4'd10, 1'b1});
      end
      nextCycle();
      testsRun++;
      if (outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL bp_idle: got %b expected 0", outValid);
      end
   endtask

   task automatic test_full_mask();
      inValid = 1'b1; inMask = 16'hFFFF; outReady = 1'b1;
      nextCycle();
      inValid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         testsRun++;
         if ({outValid, outPos, outLast} !== {1'b1, 4'(15 - i), (i == 15)}) begin
            testsFailed++;
            $display("[TB] FAIL full_beat%0d: got %b expected %b", i, {outValid, outPos, outLast}, {1'b1, 4'(15 - i), (i == 15)});
         end
         nextCycle();
      end
      testsRun++;
      if (outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL full_idle: got %b expected 0", outValid);
      end
   endtask

   task automatic test_max_beats();
      inValidB = 1'b1; inMaskB = 16'hFFFF; outReadyB = 1'b1;
      nextCycle();
      inValidB = 1'b0;
      testsRun++;
      if ({outValidB, outPosB, outLastB} !== {1'b1, 4'd15, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL cap_beat0: got %b expected %b", {outValidB, outPosB, outLastB}, {1'b1, 4'd15, 1'b0});
      end
      nextCycle();
      testsRun++;
      if ({outValidB, outPosB, outLastB} !== {1'b1, 4'd14, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL cap_beat1: got %b expected %b", {outValidB, outPosB, outLastB}, {1'b1, 4'd14, 1'b1});
      end
      nextCycle();
      testsRun++;
      if ({outValidB, inReadyB} !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL cap_dropped: got %b expected 01", {outValidB, inReadyB});
      end
   endtask

   task automatic test_reset_mid_mask();
      inValid = 1'b1; inMask = 16'h0F00; outReady = 1'b1;
      nextCycle();
      inValid = 1'b0;
      nextCycle();
      testsRun++;
      if ({outValid, outPos} !== {1'b1, 4'd10}) begin
         testsFailed++;
         $display("[TB] FAIL midreset_beat1: got %b expected %b", {outValid, outPos}, {1'b1, 4'd10});
      end
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      testsRun++;
      if ({outValid, inReady} !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL midreset_dropped: got %b expected 01", {outValid, inReady});
      end
      nextCycle();
      testsRun++;
      if (outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_no_beats: got %b expected 0", outValid);
      end
`ifdef SKIP_SCHED_PERF_CNT_EN
      testsRun++;
      if ({perfMasks, perfBeats} !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_perf: got %h expected 0", {perfMasks, perfBeats});
      end
`endif
   endtask

   // Scenario sequence; ends with the one summary line.
   initial begin
      test_reset();
      test_sparse_mask();
      test_zero_mask();
      test_single_bits();
      test_back_to_back();
      test_backpressure();
      test_full_mask();
      test_max_beats();
      test_reset_mid_mask();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
